// File: rtl/matrix_operand_loader_pkg.sv
// Shared constants, state encoding and flat-bus helpers
// for the 2x2 matrix operand loader.
`ifndef MOL_SLICE
`define MOL_SLICE(i) (i)*DW +: DW
`endif

package matrix_operand_loader_pkg;

    localparam int MOL_DW    = 8;
    localparam int MOL_NELEM = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [2:0] E_A00 = 3'd0;
    localparam logic [2:0] E_A01 = 3'd1;
    localparam logic [2:0] E_A10 = 3'd2;
    localparam logic [2:0] E_A11 = 3'd3;
    localparam logic [2:0] E_B00 = 3'd4;
    localparam logic [2:0] E_B01 = 3'd5;
    localparam logic [2:0] E_B10 = 3'd6;
    localparam logic [2:0] E_B11 = 3'd7;

endpackage

// File: rtl/matrix_operand_loader_operand_shadow_regs.sv
// Eight-element shadow array with indexed write and a whole-array
// commit onto the flat operand bus.
module operand_shadow_regs
    import matrix_operand_loader_pkg::*;
#(
    parameter int DW = MOL_DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [2:0]              wr_idx,
    input  logic [DW-1:0]           wr_data,
    input  logic                    commit,
    output logic [MOL_NELEM*DW-1:0] ops
);

    logic [MOL_NELEM*DW-1:0] shadow;

    // Commit happens on the same edge as the final write, so the
    // element being written is forwarded straight into the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            ops    <= '0;
        end else begin
            if (wr_en)
                shadow[`MOL_SLICE(wr_idx)] <= wr_data;
            if (commit) begin
                for (int i = 0; i < MOL_NELEM; i++) begin
                    if (wr_en && wr_idx == 3'(i))
                        ops[`MOL_SLICE(i)] <= wr_data;
                    else
                        ops[`MOL_SLICE(i)] <= shadow[`MOL_SLICE(i)];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Assembles A/B operand frames from a byte stream, fires the 2x2
// multiplier and holds the operands until it reports done.
module matrix_operand_loader
    import matrix_operand_loader_pkg::*;
#(
    parameter int DW = MOL_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [4*DW-1:0] a_flat,
    output logic [4*DW-1:0] b_flat,
    output logic            mul_start,
    input  logic            mul_done,
    output logic            busy,
    output logic            frame_err,
    input  logic            err_clr
);

    state_t state;
    logic [2:0] idx;
    logic [MOL_NELEM*DW-1:0] ops;

    logic beat;
    logic at_end;
    logic good;
    logic bad;

    assign beat   = in_valid & in_ready;
    assign at_end = (idx == E_B11);
    assign good   = beat & at_end & in_last;
    // Either the last marker arrived early or it never arrived.
    assign bad    = beat & (at_end ^ in_last);

    operand_shadow_regs #(.DW(DW)) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (beat),
        .wr_idx  (idx),
        .wr_data (in_data),
        .commit  (good),
        .ops     (ops)
    );

    assign a_flat = ops[4*DW-1:0];
    assign b_flat = ops[8*DW-1:4*DW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            idx       <= '0;
            in_ready  <= 1'b0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            if (bad)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;

            unique case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        busy <= 1'b1;
                        idx  <= idx + 3'd1;
                        if (good) begin
                            state     <= FIRE;
                            idx       <= '0;
                            in_ready  <= 1'b0;
                            mul_start <= 1'b1;
                        end else if (bad) begin
                            idx  <= '0;
                            busy <= 1'b0;
                        end
                    end
                end
                FIRE: begin
                    state    <= WAIT;
                    in_ready <= 1'b0;
                end
                WAIT: begin
                    in_ready <= 1'b0;
                    if (mul_done) begin
                        state    <= LOAD;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= LOAD;
                    idx      <= '0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed frame table, reset
// corner cases and random frames against a queue-based model.
module tb_matrix_operand_loader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [31:0]   a_flat;
    logic [31:0]   b_flat;
    logic          mul_start;
    logic          mul_done;
    logic          busy;
    logic          frame_err;
    logic          err_clr;

    always #5 clk = ~clk;

    matrix_operand_loader #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .busy      (busy),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    typedef struct {
        logic [63:0] d;
        int          n;
        int          lp;
        bit          gaps;
        bit          hold;
        bit          clr;
        bit          pre;
        bit          err;
        int          c[4];
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    int tests = 0;
    int fails = 0;

    bit          m_ready, m_start, m_busy, m_err;
    logic [31:0] m_a, m_b;
    int          m_phase;
    logic [7:0]  q[$];

    int mul_cnt = 0;
    int starts  = 0;
    int cap[4];
    bit got_beat;

    vec_t tv[7];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout, got no response, want response", name);
    endtask

    function automatic int el(logic [31:0] f, int i);
        return int'($signed(f[i*8 +: 8]));
    endfunction

    function automatic vec_t mk(logic [63:0] d, int n, int lp,
                                bit gaps, bit hold, bit clr, bit pre,
                                bit err, int c00, int c01, int c10,
                                int c11, logic [31:0] ea,
                                logic [31:0] eb);
        vec_t v;
        v.d = d; v.n = n; v.lp = lp;
        v.gaps = gaps; v.hold = hold; v.clr = clr; v.pre = pre;
        v.err = err;
        v.c[0] = c00; v.c[1] = c01; v.c[2] = c10; v.c[3] = c11;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic model_reset();
        m_ready = 0; m_start = 0; m_busy = 0; m_err = 0;
        m_a = '0; m_b = '0; m_phase = 0;
        q.delete();
    endtask

    // Frame-level model: collect bytes until a last marker or eight
    // bytes, then either publish the matrices or flag the frame.
    task automatic model_step();
        bit fire = 0;
        bit seterr = 0;
        m_start = 0;
        if (m_phase == 0) begin
            if (got_beat) begin
                q.push_back(in_data);
                m_busy = 1;
                if (in_last && q.size() == 8) begin
                    m_a = {q[3], q[2], q[1], q[0]};
                    m_b = {q[7], q[6], q[5], q[4]};
                    q.delete();
                    fire = 1;
                end else if (in_last || q.size() == 8) begin
                    q.delete();
                    m_busy = 0;
                    seterr = 1;
                end
            end
            if (fire) begin
                m_phase = 1; m_start = 1; m_ready = 0;
            end else begin
                m_ready = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_ready = 0;
        end else if (mul_done) begin
            m_phase = 0; m_busy = 0; m_ready = 1;
        end
        if (seterr)
            m_err = 1;
        else if (err_clr)
            m_err = 0;
    endtask

    task automatic compare_all();
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("mul_start", 64'(mul_start), 64'(m_start));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("a_flat", 64'(a_flat), 64'(m_a));
        chk("b_flat", 64'(b_flat), 64'(m_b));
    endtask

    // One clock: the stand-in multiplier drives done, the model
    // predicts the edge, then outputs are compared on the falling edge.
    task automatic cycle();
        mul_done = 1'b0;
        if (mul_cnt > 0) begin
            mul_done = (mul_cnt == 1);
            mul_cnt--;
        end else if ($urandom_range(0, 7) == 0) begin
            mul_done = 1'b1;
        end
        got_beat = in_valid && m_ready;
        model_step();
        @(negedge clk);
        compare_all();
        if (mul_start) begin
            cap[0] = el(a_flat, 0) * el(b_flat, 0) + el(a_flat, 1) * el(b_flat, 2);
            cap[1] = el(a_flat, 0) * el(b_flat, 1) + el(a_flat, 1) * el(b_flat, 3);
            cap[2] = el(a_flat, 2) * el(b_flat, 0) + el(a_flat, 3) * el(b_flat, 2);
            cap[3] = el(a_flat, 2) * el(b_flat, 1) + el(a_flat, 3) * el(b_flat, 3);
            mul_cnt = $urandom_range(2, 5);
            starts++;
        end
    endtask

    task automatic send_frame(vec_t v);
        int budget;
        if (v.pre) begin
            in_valid = 0; err_clr = 1;
            cycle();
            err_clr = 0;
        end
        for (int k = 0; k < v.n; k++) begin
            if (v.gaps) begin
                in_valid = 0;
                in_last  = 1'($urandom);
                in_data  = 8'($urandom);
                cycle();
            end
            in_valid = 1;
            in_data  = v.d[k*8 +: 8];
            in_last  = (k == v.lp);
            err_clr  = v.clr && (k == v.n - 1);
            budget = 0;
            do begin
                cycle();
                budget++;
            end while (!got_beat && budget < 50);
            if (!got_beat) timeout("beat accept");
        end
        in_valid = v.hold;
        in_last  = 0;
        err_clr  = 0;
        budget   = 0;
        while ((m_phase != 0 || !m_ready) && budget < 50) begin
            cycle();
            budget++;
            if (m_phase == 0) in_valid = 0;
        end
        in_valid = 0;
        if (budget >= 50) timeout("frame completion");
    endtask

    initial begin
        int s0;
        vec_t v;
        int kind;

        tv[0] = mk(64'h0807060504030201, 8, 7, 0, 0, 0, 0, 0,
                   19, 22, 43, 50, 32'h04030201, 32'h08070605);
        tv[1] = mk(64'h0807FA050403FEFF, 8, 7, 1, 0, 0, 0, 0,
                   -19, -10, 43, 14, 32'h0403FEFF, 32'h0807FA05);
        tv[2] = mk(64'h0807060504030201, 8, 7, 0, 1, 0, 0, 0,
                   19, 22, 43, 50, 32'h04030201, 32'h08070605);
        tv[3] = mk(64'h0807FA050403FEFF, 5, 4, 0, 0, 0, 0, 1,
                   0, 0, 0, 0, 32'h04030201, 32'h08070605);
        tv[4] = mk(64'h0807FA050403FEFF, 8, 7, 0, 0, 0, 1, 0,
                   -19, -10, 43, 14, 32'h0403FEFF, 32'h0807FA05);
        tv[5] = mk(64'h0807060504030201, 8, -1, 0, 0, 1, 0, 1,
                   0, 0, 0, 0, 32'h0403FEFF, 32'h0807FA05);
        tv[6] = mk(64'h0807060504030201, 8, 7, 0, 0, 0, 1, 0,
                   19, 22, 43, 50, 32'h04030201, 32'h08070605);

        in_data = '0; in_valid = 0; in_last = 0;
        err_clr = 0; mul_done = 0; rst = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1;
        cycle();
        chk("ready after release", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            s0 = starts;
            send_frame(tv[i]);
            chk($sformatf("v%0d frame_err", i), 64'(frame_err), 64'(tv[i].err));
            chk($sformatf("v%0d a_flat", i), 64'(a_flat), 64'(tv[i].ea));
            chk($sformatf("v%0d b_flat", i), 64'(b_flat), 64'(tv[i].eb));
            if (tv[i].err) begin
                chk($sformatf("v%0d starts", i), 64'(starts), 64'(s0));
            end else begin
                chk($sformatf("v%0d starts", i), 64'(starts), 64'(s0 + 1));
                for (int k = 0; k < 4; k++)
                    chk($sformatf("v%0d c%0d", i, k), 64'(cap[k]), 64'(tv[i].c[k]));
            end
        end

        // Reset asserted part-way through a frame.
        s0 = starts;
        in_last = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1;
            in_data  = 8'(8'hA0 + k);
            cycle();
        end
        in_valid = 0;
        #1 rst = 0;
        #1;
        model_reset();
        mul_cnt = 0;
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1;
        cycle();
        send_frame(tv[0]);
        chk("reset frame starts", 64'(starts), 64'(s0 + 1));
        chk("reset frame a_flat", 64'(a_flat), 64'h04030201);
        chk("reset frame c00", 64'(cap[0]), 64'(19));
        chk("reset frame c11", 64'(cap[3]), 64'(50));

        for (int r = 0; r < 40; r++) begin
            v = tv[0];
            v.d = {$urandom, $urandom};
            kind = $urandom_range(0, 9);
            v.n = 8;
            v.lp = 7;
            if (kind == 8) begin
                v.lp = $urandom_range(0, 6);
                v.n  = v.lp + 1;
            end else if (kind == 9) begin
                v.lp = -1;
            end
            v.gaps = 1'($urandom);
            v.hold = 1'($urandom);
            v.clr  = 1'($urandom);
            v.pre  = ($urandom_range(0, 3) == 0);
            send_frame(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
